spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync.sv | 51 +++++
 rtl/spi_slave.sv | 157 +++++++++++++++
 tb/tb_spi_slave.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both spi_slave and spi_master.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Bit-counter width for a word of w bits, never narrower than one bit.
    function automatic int spi_cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer for an asynchronous input, with optional rise/fall
// detection on the synchronized level.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0,
    parameter bit   EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= {STAGES{RST_VAL}};
        end else begin
            sync_p0[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_p0[i] <= sync_p0[i-1];
            end
        end
    end

    assign q = sync_p0[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_p1;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    prev_p1 <= RST_VAL;
                end else begin
                    prev_p1 <= q;
                end
            end

            assign rise = q & ~prev_p1;
            assign fall = ~q & prev_p1;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled by clk, single-entry tx buffer, back-to-back
// words permitted while ss_n stays low.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss_n,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int               CNT_W    = spi_cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic       sclk_lvl_unused;
    logic       sclk_rise_p0;
    logic       sclk_fall_p0;
    logic       mosi_p0;
    logic       ss_n_p0;
    logic [1:0] mosi_edge_unused;
    logic [1:0] ss_edge_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sclk),
        .q    (sclk_lvl_unused),
        .rise (sclk_rise_p0),
        .fall (sclk_fall_p0)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (mosi),
        .q    (mosi_p0),
        .rise (mosi_edge_unused[0]),
        .fall (mosi_edge_unused[1])
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b0)) u_sync_ss (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ss_n),
        .q    (ss_n_p0),
        .rise (ss_edge_unused[0]),
        .fall (ss_edge_unused[1])
    );

    logic [0:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic [DATA_WIDTH-1:0] next_word;
    logic                  tx_full;
    logic                  start;
    logic                  stop;
    logic                  bit_rise;
    logic                  bit_fall;
    logic                  word_done;
    logic                  reload;
    logic                  consume;
    logic                  load;

    // Synchronized ss_n resets to 1, so seeing it low while IDLE is always a
    // falling edge that this FSM has not yet acted on.
    assign start     = (state == ST_IDLE) && !ss_n_p0;
    assign stop      = (state == ST_ACTIVE) && ss_n_p0;
    assign bit_rise  = (state == ST_ACTIVE) && !ss_n_p0 && sclk_rise_p0;
    assign bit_fall  = (state == ST_ACTIVE) && !ss_n_p0 && sclk_fall_p0;
    assign word_done = bit_rise && (bit_cnt == LAST_BIT);
    assign reload    = bit_fall && (bit_cnt == '0);
    assign consume   = start || reload;
    assign tx_ready  = !tx_full && !consume;
    assign load      = tx_valid && tx_ready;
    assign next_word = tx_full ? tx_buf : '0;
    assign rx_word   = {rx_shift, mosi_p0};

    // ---- stage p1: control state ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_valid <= 1'b0;
            tx_full  <= 1'b0;
        end else begin
            rx_valid <= word_done;

            if (start) begin
                state   <= ST_ACTIVE;
                bit_cnt <= '0;
            end else if (stop) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else if (bit_rise) begin
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end

            if (consume) begin
                tx_full <= 1'b0;
            end else if (load) begin
                tx_full <= 1'b1;
            end
        end
    end

    // ---- stage p1: shift registers and buffers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_shift <= '0;
            tx_shift <= '0;
            tx_buf   <= '0;
            rx_data  <= '0;
        end else begin
            if (load) begin
                tx_buf <= tx_data;
            end

            if (start) begin
                rx_shift <= '0;
                tx_shift <= next_word;
            end else if (stop) begin
                rx_shift <= '0;
                tx_shift <= '0;
            end else begin
                if (bit_rise) begin
                    rx_shift <= rx_word[DATA_WIDTH-2:0];
                end
                if (word_done) begin
                    rx_data <= rx_word;
                end
                if (reload) begin
                    tx_shift <= next_word;
                end else if (bit_fall) begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign busy = (state == ST_ACTIVE);
    assign miso = busy ? tx_shift[DATA_WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: behavioural mode-0 master (8 clk per sclk period),
// table-driven directed transfers, corner sequences and randomized traffic.
module tb_spi_slave;

    localparam int DW   = 8;
    localparam int HALF = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          sclk     = 1'b0;
    logic          mosi     = 1'b0;
    logic          ss_n     = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic          miso;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk    (sclk),
        .mosi    (mosi),
        .ss_n    (ss_n),
        .miso    (miso),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] rx_log[$];
    int            miso_hi = 0;

    // Reference slave tx buffer: at most one pending word.
    logic [DW-1:0] mbuf[$];

    logic [DW-1:0] m_tx[4];
    logic [DW-1:0] m_rx[4];
    logic [DW-1:0] m_exp[4];
    logic [DW-1:0] m_ld_val[4];
    logic          m_ld_en[4];

    typedef struct {
        string         name;
        int            nwords;
        logic [DW-1:0] mtx0;
        logic [DW-1:0] mtx1;
        bit            pre_en;
        logic [DW-1:0] pre;
        bit            mid_en;
        logic [DW-1:0] mid;
        logic [DW-1:0] exp_m0;
        logic [DW-1:0] exp_m1;
        bit            miso_quiet;
    } vec_t;

    vec_t vecs[3];

    always @(negedge clk) begin
        if (rx_valid) rx_log.push_back(rx_data);
        if (miso) miso_hi++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] take_buf();
        logic [DW-1:0] v;
        v = '0;
        if (mbuf.size() != 0) v = mbuf.pop_front();
        return v;
    endfunction

    function automatic logic [DW-1:0] rx_at(input int i);
        logic [DW-1:0] v;
        v = 'x;
        if (i < rx_log.size()) v = rx_log[i];
        return v;
    endfunction

    task automatic offer(input logic [DW-1:0] v, input string name);
        logic exp_rdy;
        exp_rdy = (mbuf.size() == 0);
        check({name, " tx_ready"}, 32'(tx_ready), 32'(exp_rdy));
        tx_data  = v;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (exp_rdy) mbuf.push_back(v);
    endtask

    // Master: MSB first, mosi changes on fall, miso sampled on rise.
    // abort_after >= 0 raises ss_n after that many sclk rises.
    task automatic xfer(input int nwords, input int abort_after);
        int done;
        bit stop;
        done = 0;
        stop = 1'b0;
        ss_n = 1'b0;
        m_exp[0] = take_buf();
        repeat (2*HALF) @(negedge clk);
        for (int w = 0; w < nwords && !stop; w++) begin
            for (int b = DW-1; b >= 0; b--) begin
                if (done == abort_after) begin
                    stop = 1'b1;
                    break;
                end
                mosi = m_tx[w][b];
                if (b == 3 && m_ld_en[w]) begin
                    offer(m_ld_val[w], "mid-word load");
                    repeat (HALF-1) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
                sclk = 1'b1;
                m_rx[w][b] = miso;
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
                done++;
            end
            if (!stop) begin
                if (w + 1 < nwords) m_exp[w+1] = take_buf();
                else void'(take_buf());
            end
        end
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (4*HALF) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int nw;
        int npre;

        vecs[0] = '{"single A5", 1, 8'hA5, 8'h00, 1'b1, 8'h3C, 1'b0, 8'h00, 8'h3C, 8'h00, 1'b0};
        vecs[1] = '{"b2b 55 AA", 2, 8'h55, 8'hAA, 1'b1, 8'hC3, 1'b1, 8'h3C, 8'hC3, 8'h3C, 1'b0};
        vecs[2] = '{"empty FF",  1, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
        for (int i = 0; i < 4; i++) m_ld_en[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("reset miso",     32'(miso),     32'(0));
        check("reset tx_ready", 32'(tx_ready), 32'(1));
        check("reset rx_data",  32'(rx_data),  32'(0));
        check("reset rx_valid", 32'(rx_valid), 32'(0));
        check("reset busy",     32'(busy),     32'(0));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            base    = rx_log.size();
            miso_hi = 0;
            if (vecs[i].pre_en) offer(vecs[i].pre, {vecs[i].name, " preload"});
            m_tx[0]     = vecs[i].mtx0;
            m_tx[1]     = vecs[i].mtx1;
            m_ld_en[0]  = vecs[i].mid_en;
            m_ld_val[0] = vecs[i].mid;
            m_ld_en[1]  = 1'b0;
            xfer(vecs[i].nwords, -1);
            check({vecs[i].name, " rx_valid count"}, 32'(rx_log.size() - base), 32'(vecs[i].nwords));
            check({vecs[i].name, " rx word0"}, 32'(rx_at(base)), 32'(vecs[i].mtx0));
            check({vecs[i].name, " master word0"}, 32'(m_rx[0]), 32'(vecs[i].exp_m0));
            if (vecs[i].nwords > 1) begin
                check({vecs[i].name, " rx word1"}, 32'(rx_at(base + 1)), 32'(vecs[i].mtx1));
                check({vecs[i].name, " master word1"}, 32'(m_rx[1]), 32'(vecs[i].exp_m1));
            end
            if (vecs[i].miso_quiet) check({vecs[i].name, " miso high clks"}, 32'(miso_hi), 32'(0));
            check({vecs[i].name, " busy after"}, 32'(busy), 32'(0));
        end
        m_ld_en[0] = 1'b0;

        // Partial word: three rises, then deselect.
        base    = rx_log.size();
        m_tx[0] = 8'hF0;
        xfer(1, 3);
        check("abort rx_valid count", 32'(rx_log.size() - base), 32'(0));
        check("abort busy",           32'(busy),                 32'(0));
        check("abort rx_data kept",   32'(rx_data),              32'(8'hFF));
        m_tx[0] = 8'h0F;
        xfer(1, -1);
        check("after abort count",  32'(rx_log.size() - base), 32'(1));
        check("after abort rx",     32'(rx_at(base)),          32'(8'h0F));
        check("after abort master", 32'(m_rx[0]),              32'(8'h00));

        // Full buffer must ignore a held tx_valid.
        offer(8'h3C, "hold preload");
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("held tx_ready", 32'(tx_ready), 32'(mbuf.size() == 0));
        end
        tx_valid = 1'b0;
        @(negedge clk);
        base    = rx_log.size();
        m_tx[0] = 8'h12;
        xfer(1, -1);
        check("held master word", 32'(m_rx[0]),     32'(8'h3C));
        check("held rx word",     32'(rx_at(base)), 32'(8'h12));

        // Reset in the middle of a word.
        base    = rx_log.size();
        m_tx[0] = 8'hC7;
        fork
            xfer(1, -1);
            begin
                repeat (30) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("midreset miso",     32'(miso),     32'(0));
                check("midreset tx_ready", 32'(tx_ready), 32'(1));
                check("midreset rx_data",  32'(rx_data),  32'(0));
                check("midreset rx_valid", 32'(rx_valid), 32'(0));
                check("midreset busy",     32'(busy),     32'(0));
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        mbuf.delete();
        check("midreset rx_valid count", 32'(rx_log.size() - base), 32'(0));
        repeat (4) @(negedge clk);

        // Randomized traffic against the buffer/word model.
        for (int it = 0; it < 12; it++) begin
            nw = int'($urandom_range(1, 3));
            for (int w = 0; w < 4; w++) begin
                m_tx[w]     = DW'($urandom);
                m_ld_en[w]  = (w < nw) ? 1'($urandom_range(0, 1)) : 1'b0;
                m_ld_val[w] = DW'($urandom);
            end
            npre = int'($urandom_range(0, 2));
            for (int p = 0; p < npre; p++) offer(DW'($urandom), "rand preload");
            base = rx_log.size();
            xfer(nw, -1);
            check("rand rx_valid count", 32'(rx_log.size() - base), 32'(nw));
            for (int w = 0; w < nw; w++) begin
                check("rand rx word",     32'(rx_at(base + w)), 32'(m_tx[w]));
                check("rand master word", 32'(m_rx[w]),         32'(m_exp[w]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
